// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - circular store buffer with load forwarding and drain FSM
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        st_valid,
    input  logic [4:0]  st_addr,
    input  logic [31:0] st_data,
    output logic        st_ready,
    input  logic [4:0]  ld_addr,
    output logic        ld_hit,
    output logic [31:0] ld_data,
    output logic        mem_we,
    output logic [4:0]  mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic        flush,
    output logic        empty,
    output logic        ovf
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;

    logic [4:0]       ent_addr [DEPTH];
    logic [31:0]      ent_data [DEPTH];
    logic [DEPTH-1:0] ent_valid;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] fwd_idx;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic          flush_mode;
    logic          push;
    logic          pop;
    logic          busy;

    // Acceptance depends only on registered state so the processor sees a stable ready.
    assign st_ready = (count < FULL_COUNT) && !flush_mode;
    assign push     = st_valid && st_ready;
    assign busy     = (state != S_IDLE);
    assign pop      = busy && mem_ack;

    // The head entry cannot change while a write is outstanding, so these stay stable in WAIT.
    assign mem_we    = busy;
    assign mem_addr  = busy ? ent_addr[head] : '0;
    assign mem_wdata = busy ? ent_data[head] : '0;
    assign empty     = (count == '0) && (state == S_IDLE);

    // Occupancy after this edge, accounting for a simultaneous push and pop.
    always_comb begin
        count_nxt = count;
        case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Drain FSM: issue the head entry and hold it until memory acknowledges.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  state_nxt = (count != '0) ? S_ISSUE : S_IDLE;
            S_ISSUE: begin
                if (mem_ack) state_nxt = (count_nxt == '0) ? S_IDLE : S_ISSUE;
                else         state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (mem_ack) state_nxt = (count_nxt == '0) ? S_IDLE : S_ISSUE;
                else         state_nxt = S_WAIT;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Forwarding scan from oldest to youngest so the youngest match wins.
    always_comb begin
        ld_hit  = 1'b0;
        ld_data = '0;
        fwd_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head + PW'(i);
            if (ent_valid[fwd_idx] && (ent_addr[fwd_idx] == ld_addr)) begin
                ld_hit  = 1'b1;
                ld_data = ent_data[fwd_idx];
            end
        end
    end

    // Entry payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            ent_addr[tail] <= st_addr;
            ent_data[tail] <= st_data;
        end
    end

    // Pointers, occupancy, FSM state and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            state      <= S_IDLE;
            ent_valid  <= '0;
            ovf        <= 1'b0;
            flush_mode <= 1'b0;
        end else begin
            count <= count_nxt;
            state <= state_nxt;
            if (pop) begin
                ent_valid[head] <= 1'b0;
                head            <= head + PW'(1);
            end
            if (push) begin
                ent_valid[tail] <= 1'b1;
                tail            <= tail + PW'(1);
            end
            if (st_valid && !st_ready) begin
                ovf <= 1'b1;
            end
            if (flush) begin
                flush_mode <= 1'b1;
            end else if ((count == '0) && (state == S_IDLE)) begin
                flush_mode <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// tb/tb_store_buffer.sv - self-checking bench for store_buffer
module tb_store_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        st_valid;
    logic [4:0]  st_addr;
    logic [31:0] st_data;
    logic        st_ready;
    logic [4:0]  ld_addr;
    logic        ld_hit;
    logic [31:0] ld_data;
    logic        mem_we;
    logic [4:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic        flush;
    logic        empty;
    logic        ovf;

    int tests = 0;
    int fails = 0;
    logic [36:0] sb[$];

    typedef struct {
        logic [4:0]  addr;
        logic        hit;
        logic [31:0] data;
    } fwd_vec_t;

    store_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_ready(st_ready),
        .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .flush(flush), .empty(empty), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Called at a negedge; the store is presented for exactly one posedge.
    task automatic push_store(input logic [4:0] a, input logic [31:0] d, input logic exp_ready);
        chk("st_ready_before_push", st_ready, exp_ready);
        st_valid = 1'b1;
        st_addr  = a;
        st_data  = d;
        if (exp_ready) sb.push_back({a, d});
        @(negedge clk);
        st_valid = 1'b0;
    endtask

    task automatic apply_reset();
        rst_n    = 1'b0;
        st_valid = 1'b0;
        flush    = 1'b0;
        mem_ack  = 1'b0;
        repeat (2) @(negedge clk);
        sb.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_empty(input int max_cycles);
        for (int k = 0; k < max_cycles; k++) begin
            if (empty) break;
            @(negedge clk);
        end
        chk("drain_reaches_empty", empty, 1'b1);
    endtask

    // Scoreboard: every accepted memory write must match the oldest expected store.
    task automatic monitor();
        logic [36:0] e;
        forever begin
            @(negedge clk);
            #4;
            if (rst_n && mem_we && mem_ack) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_write: got addr %h data %h, required no write",
                             mem_addr, mem_wdata);
                end else begin
                    e = sb.pop_front();
                    chk("sb_mem_addr", 32'(mem_addr), 32'(e[36:32]));
                    chk("sb_mem_wdata", mem_wdata, e[31:0]);
                end
            end
        end
    endtask

    initial begin
        fwd_vec_t fv[5];
        fv[0] = '{addr: 5'h08, hit: 1'b1, data: 32'h22222222};
        fv[1] = '{addr: 5'h0C, hit: 1'b0, data: 32'h00000000};
        fv[2] = '{addr: 5'h10, hit: 1'b1, data: 32'h33333333};
        fv[3] = '{addr: 5'h14, hit: 1'b1, data: 32'h44444444};
        fv[4] = '{addr: 5'h00, hit: 1'b0, data: 32'h00000000};

        rst_n = 1'b0; st_valid = 1'b0; st_addr = '0; st_data = '0;
        ld_addr = 5'h04; mem_ack = 1'b0; flush = 1'b0;
        fork monitor(); join_none

        // Reset values
        step();
        chk("rst_st_ready", st_ready, 1'b1);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h0);
        chk("rst_mem_wdata", mem_wdata, 32'h0);
        chk("rst_ld_hit", ld_hit, 1'b0);
        chk("rst_ld_data", ld_data, 32'h0);
        chk("rst_empty", empty, 1'b1);
        chk("rst_ovf", ovf, 1'b0);
        step();
        rst_n = 1'b1;
        step();

        // Single store, two-cycle latency to mem_we
        mem_ack = 1'b1;
        push_store(5'h04, 32'hDEADBEEF, 1'b1);
        chk("single_we_after_push", mem_we, 1'b0);
        chk("single_fwd_hit", ld_hit, 1'b1);
        chk("single_fwd_data", ld_data, 32'hDEADBEEF);
        step();
        chk("single_we", mem_we, 1'b1);
        chk("single_addr", 32'(mem_addr), 32'h04);
        chk("single_data", mem_wdata, 32'hDEADBEEF);
        step();
        chk("single_empty", empty, 1'b1);
        chk("single_we_off", mem_we, 1'b0);
        chk("single_addr_zero", 32'(mem_addr), 32'h0);

        // Fill and overflow with memory stalled
        mem_ack = 1'b0;
        push_store(5'h08, 32'h11111111, 1'b1);
        push_store(5'h08, 32'h22222222, 1'b1);
        push_store(5'h10, 32'h33333333, 1'b1);
        push_store(5'h14, 32'h44444444, 1'b1);
        push_store(5'h0C, 32'h55555555, 1'b0);
        chk("fill_ovf", ovf, 1'b1);
        chk("fill_mem_addr_first", 32'(mem_addr), 32'h08);

        // Forwarding table against the full buffer
        for (int i = 0; i < 5; i++) begin
            ld_addr = fv[i].addr;
            #1;
            chk($sformatf("fwd_hit_%0d", i), ld_hit, fv[i].hit);
            chk($sformatf("fwd_data_%0d", i), ld_data, fv[i].data);
        end
        step();

        // Back-pressure: three stalled cycles then one ack, outputs stable throughout
        for (int i = 0; i < 4; i++) begin
            mem_ack = (i == 3);
            chk("bp_we", mem_we, 1'b1);
            chk("bp_addr", 32'(mem_addr), 32'h08);
            chk("bp_data", mem_wdata, 32'h11111111);
            step();
        end
        mem_ack = 1'b0;
        chk("bp_next_addr", 32'(mem_addr), 32'h08);
        chk("bp_next_data", mem_wdata, 32'h22222222);
        chk("bp_ovf_sticky", ovf, 1'b1);
        mem_ack = 1'b1;
        wait_empty(20);
        chk("bp_sb_drained", 32'(sb.size()), 32'h0);

        // Back-to-back push/pop across pointer wrap
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) chk("wrap_we_busy", mem_we, 1'b1);
            push_store(5'(i * 3 + 1), 32'hA0000000 + 32'(i), 1'b1);
        end
        wait_empty(20);
        chk("wrap_sb_drained", 32'(sb.size()), 32'h0);

        // Flush drains and blocks stores until empty
        apply_reset();
        push_store(5'h01, 32'h0000F001, 1'b1);
        push_store(5'h02, 32'h0000F002, 1'b1);
        push_store(5'h03, 32'h0000F003, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_blocks", st_ready, 1'b0);
        mem_ack = 1'b1;
        for (int k = 0; k < 30; k++) begin
            if (empty) break;
            chk("flush_ready_low", st_ready, 1'b0);
            step();
        end
        chk("flush_empty", empty, 1'b1);
        step();
        chk("flush_released", st_ready, 1'b1);
        chk("flush_sb_drained", 32'(sb.size()), 32'h0);

        // Reset while a write is outstanding in WAIT
        apply_reset();
        push_store(5'h11, 32'hCAFE0001, 1'b1);
        push_store(5'h12, 32'hCAFE0002, 1'b1);
        push_store(5'h13, 32'hCAFE0003, 1'b1);
        push_store(5'h14, 32'hCAFE0004, 1'b1);
        push_store(5'h15, 32'hCAFE0005, 1'b0);
        chk("wait_we", mem_we, 1'b1);
        chk("wait_ovf", ovf, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_we", mem_we, 1'b0);
        chk("async_rst_empty", empty, 1'b1);
        chk("async_rst_ovf", ovf, 1'b0);
        chk("async_rst_ready", st_ready, 1'b1);
        chk("async_rst_mem_addr", 32'(mem_addr), 32'h0);
        sb.delete();
        step();
        rst_n = 1'b1;
        mem_ack = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("post_rst_no_we", mem_we, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameter DEPTH, default 4, meaning number of buffered stores; legal values 2, 4 or 8.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 st_valid  in  1  processor store request, driven from memwrite.
REQ-005 st_addr  in  5  byte address of the store (ALU sum[4:0]).
REQ-006 st_data  in  32  store word, big-endian (datab).
REQ-007 st_ready  out  1  buffer can accept a store this cycle.
REQ-008 ld_addr  in  5  load byte address, used for forwarding lookup.
REQ-009 ld_hit  out  1  a buffered store matches ld_addr.
REQ-010 ld_data  out  32  data of the newest matching entry; 0 when ld_hit=0.
REQ-011 mem_we  out  1  write request to data memory.
REQ-012 mem_addr  out  5  data memory byte address.
REQ-013 mem_wdata  out  32  data memory write word.
REQ-014 mem_ack  in  1  data memory accepted the write this cycle.
REQ-015 flush  in  1  drain request: block new stores until the buffer is empty.
REQ-016 empty  out  1  no entries buffered and no write outstanding.
REQ-017 ovf  out  1  sticky flag: a store arrived while st_ready=0.

Function
REQ-018 Entries form a circular FIFO with head/tail pointers of log2(DEPTH) bits and a count of log2(DEPTH)+1 bits; pointers wrap from DEPTH-1 to 0.
REQ-019 A push occurs on posedge when st_valid=1 and st_ready=1; the entry {st_addr, st_data} is written at tail and tail increments.
REQ-020 st_ready = (count<DEPTH) and not flush_mode; it is combinational from registered state only.
REQ-021 A store with st_valid=1 and st_ready=0 is dropped, and ovf is set on that posedge and held until reset.
REQ-022 Drain FSM states: IDLE, ISSUE, WAIT.
REQ-023 IDLE: if count>0, go to ISSUE next cycle; else stay in IDLE.
REQ-024 ISSUE: mem_we=1, mem_addr/mem_wdata = head entry; on mem_ack=1 pop (head++), then go to IDLE if count becomes 0, else stay in ISSUE; on mem_ack=0 go to WAIT.
REQ-025 WAIT: mem_we, mem_addr and mem_wdata are held stable; on mem_ack=1 pop and apply the same exit rule as ISSUE.
REQ-026 mem_we=0 in IDLE, and mem_addr/mem_wdata=0 when mem_we=0.
REQ-027 Minimum latency from push to mem_we=1 is 2 cycles from an empty buffer (push edge, IDLE->ISSUE edge).
REQ-028 Throughput is one pop per cycle while mem_ack stays high.
REQ-029 A push and a pop on the same edge leave count unchanged; both operations take effect.
REQ-030 A push while full and a pop on the same edge is still dropped, because st_ready is based on the pre-edge count.
REQ-031 Forwarding: compare ld_addr exactly against st_addr of every valid entry, including the head being written; ld_data comes from the youngest match (closest to tail); combinational.
REQ-032 A store pushed on the current edge is visible to forwarding from the next cycle onward.
REQ-033 flush=1 sets flush_mode; flush_mode clears on the first cycle with count=0 and FSM in IDLE.
REQ-034 empty = (count==0) and FSM in IDLE.
REQ-035 mem_ack received in IDLE is ignored.

Reset
REQ-036 While rst_n=0, asynchronously: count, head and tail = 0; FSM = IDLE; ovf = 0; flush_mode = 0; entry valid bits cleared.
REQ-037 Reset outputs: st_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, ld_hit=0, ld_data=0, empty=1.
REQ-038 Reset asserted mid-write discards all entries, including one in WAIT; no further mem_we is issued.

Verification
REQ-039 Single store: push addr 5'h04 data 32'hDEADBEEF with mem_ack=1 -> mem_we=1 two cycles later with addr 04 and data DEADBEEF; empty=1 on the following cycle.
REQ-040 Fill and overflow (DEPTH=4, mem_ack=0): push 5 stores -> st_ready=0 after the 4th push; the 5th store is dropped; ovf=1; mem_addr holds the first address.
REQ-041 Forwarding: push addr 08 data 11111111, then addr 08 data 22222222, with mem_ack=0 -> ld_addr=08 gives ld_hit=1, ld_data=22222222; ld_addr=0C gives ld_hit=0, ld_data=0.
REQ-042 Back-pressure: hold mem_ack=0 for 3 cycles then 1 -> mem_we/mem_addr/mem_wdata stable for all 4 cycles; exactly one pop.
REQ-043 Simultaneous push/pop with count=2 and mem_ack=1 -> count stays 2; FIFO order is preserved across pointer wrap for 10 stores.
REQ-044 Flush plus reset: assert flush with 3 entries -> st_ready=0 until empty=1; rerun the test and pull rst_n low while in WAIT -> mem_we=0 immediately, empty=1, ovf=0.
